// File: rtl/grid_loader_pkg.sv
// Shared types and constants for the serial grid loader.
package grid_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHECK
  } loader_state_e;

endpackage

// File: rtl/memory_bus.sv
// Simple single-port write bus between a bulk loader and the grid memory.
interface memory_bus #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;

  modport client (output address, output write_data, output write_enable);
  modport target (input address, input write_data, input write_enable);
endinterface

// File: rtl/byte_packer.sv
// Packs bytes least-significant first into a DATA_WIDTH word; flags the byte that completes a word.
module byte_packer
  import grid_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [DATA_WIDTH-1:0] word_c,
  output logic                  word_ready_c
);

  localparam int unsigned BPW   = DATA_WIDTH / BYTE_W;
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // New byte enters at the top so the first byte ends up in the low lane.
  always_comb begin
    word_c       = (word_q >> BYTE_W) | (DATA_WIDTH'(byte_in) << (DATA_WIDTH - BYTE_W));
    word_ready_c = (idx_q == IDX_W'(BPW - 1));
    word_d       = word_q;
    idx_d        = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_en) begin
      word_d = word_c;
      idx_d  = word_ready_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/serial_grid_loader.sv
// Framed serial byte stream to memory_bus word writer with per-frame checksum reporting.
module serial_grid_loader
  import grid_loader_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 16,
  parameter int unsigned       DATA_WIDTH = 8,
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  memory_bus.client             mem,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
);

  localparam int unsigned CMP_W = 33;

  generate
    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH == 0) begin : g_bad_width
      $error("serial_grid_loader: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  loader_state_e         state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BYTE_W-1:0]     chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] ww_q, ww_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept_c;
  logic [LEN_W-1:0]      len_new_c;
  logic                  pk_clear_c, pk_shift_c, pk_ready_c;
  logic [DATA_WIDTH-1:0] pk_word_c;

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (pk_clear_c),
    .shift_en     (pk_shift_c),
    .byte_in      (rx_data),
    .word_c       (pk_word_c),
    .word_ready_c (pk_ready_c)
  );

  // Next-state, counters, checksum and registered-output decode.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    ww_d       = ww_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    pk_clear_c = 1'b0;
    pk_shift_c = 1'b0;
    accept_c   = rx_valid && ready_q;
    len_new_c  = {rx_data, len_q[BYTE_W-1:0]};

    // The write already happened on the bus, so count it even if the frame aborts now.
    if (state_q == WRITE) begin
      ww_d = ww_q + ADDR_WIDTH'(1);
    end

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c && rx_data == SYNC_BYTE) begin
            state_d    = LEN_LO;
            ww_d       = '0;
            chk_d      = '0;
            pk_clear_c = 1'b1;
          end
        end
        LEN_LO: begin
          if (accept_c) begin
            len_d[BYTE_W-1:0] = rx_data;
            state_d           = LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept_c) begin
            len_d = len_new_c;
            if (CMP_W'(len_new_c) >= (CMP_W'(1) << ADDR_WIDTH)) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else if (len_new_c == '0) begin
              state_d = CHECK;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (accept_c) begin
            pk_shift_c = 1'b1;
            chk_d      = chk_q ^ rx_data;
            if (pk_ready_c) begin
              state_d = WRITE;
              addr_d  = ww_q;
              wdata_d = pk_word_c;
            end
          end
        end
        WRITE: begin
          state_d = (CMP_W'(ww_q) + CMP_W'(1) == CMP_W'(len_q)) ? CHECK : DATA;
        end
        CHECK: begin
          if (accept_c) begin
            if (rx_data == chk_q) begin
              done_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    we_d    = (state_d == WRITE);
    ready_d = (state_d != WRITE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      ww_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      ww_q    <= ww_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign rx_ready         = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_written    = ww_q;
  assign mem.address      = addr_q;
  assign mem.write_data   = wdata_q;
  assign mem.write_enable = we_q;

endmodule

// File: tb/tb_serial_grid_loader.sv
// Directed bench for serial_grid_loader: three configurations, each with a small memory model.
module tb_serial_grid_loader;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  int         sel;

  int n_vec = 0;
  int n_bad = 0;

  // 0: AW16/DW16, 1: AW4/DW16, 2: AW16/DW8
  logic        v16, v4, v8;
  logic        rdy16, rdy4, rdy8;
  logic        busy16, busy4, busy8;
  logic        done16, done4, done8;
  logic        err16, err4, err8;
  logic [15:0] ww16, ww8;
  logic [3:0]  ww4;

  assign v16 = rx_valid && (sel == 0);
  assign v4  = rx_valid && (sel == 1);
  assign v8  = rx_valid && (sel == 2);

  memory_bus #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus16 ();
  memory_bus #(.ADDR_WIDTH(4),  .DATA_WIDTH(16)) bus4 ();
  memory_bus #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  bus8 ();

  serial_grid_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_BYTE(8'hA5)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_data(rx_data), .rx_valid(v16),
    .rx_ready(rdy16), .mem(bus16), .busy(busy16), .done(done16), .error(err16),
    .words_written(ww16));

  serial_grid_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_data(rx_data), .rx_valid(v4),
    .rx_ready(rdy4), .mem(bus4), .busy(busy4), .done(done4), .error(err4),
    .words_written(ww4));

  serial_grid_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .SYNC_BYTE(8'hA5)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_data(rx_data), .rx_valid(v8),
    .rx_ready(rdy8), .mem(bus8), .busy(busy8), .done(done8), .error(err8),
    .words_written(ww8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models capture on the rising edge, like the real grid memory.
  logic [15:0] m16 [16];
  logic [7:0]  m8  [16];
  int          wr16 = 0;
  int          wr4  = 0;
  int          wr8  = 0;
  int          addr8_log [$];
  int          we8_cycles = 0;
  int          ready_in_write8 = 0;

  always @(posedge clk) begin
    if (bus16.write_enable) begin
      m16[bus16.address[3:0]] <= bus16.write_data;
      wr16 <= wr16 + 1;
    end
    if (bus4.write_enable) wr4 <= wr4 + 1;
    if (bus8.write_enable) begin
      m8[bus8.address[3:0]] <= bus8.write_data;
      wr8 <= wr8 + 1;
      addr8_log.push_back(int'(bus8.address));
    end
  end

  always @(negedge clk) begin
    if (bus8.write_enable) begin
      we8_cycles <= we8_cycles + 1;
      if (rdy8) ready_in_write8 <= ready_in_write8 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input int k, input logic [7:0] b);
    logic rdy;
    int   n;
    n        = 0;
    rx_data  = b;
    sel      = k;
    rx_valid = 1'b1;
    forever begin
      rdy = (k == 0) ? rdy16 : (k == 1) ? rdy4 : rdy8;
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 50) begin
        n_vec++;
        n_bad++;
        $error("FAIL send_timeout: byte 0x%0h never accepted by dut %0d", b, k);
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  int base;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    sel      = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(rdy16), 32'd1);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done_err", 32'({done16, err16}), 32'd0);
    chk("rst_ww", 32'(ww16), 32'd0);
    chk("rst_addr", 32'(bus16.address), 32'd0);
    chk("rst_wdata", 32'(bus16.write_data), 32'd0);
    chk("rst_we", 32'(bus16.write_enable), 32'd0);

    // 1: two words, good checksum
    send_byte(0, 8'hA5);
    chk("t1_busy_after_sync", 32'(busy16), 32'd1);
    send_byte(0, 8'h02);
    send_byte(0, 8'h00);
    send_byte(0, 8'h34);
    chk("t1_no_we_midword", 32'(bus16.write_enable), 32'd0);
    send_byte(0, 8'h12);
    chk("t1_we_latency", 32'(bus16.write_enable), 32'd1);
    chk("t1_addr0", 32'(bus16.address), 32'd0);
    chk("t1_data0", 32'(bus16.write_data), 32'h1234);
    chk("t1_ready_in_write", 32'(rdy16), 32'd0);
    send_byte(0, 8'h78);
    send_byte(0, 8'h56);
    chk("t1_addr1", 32'(bus16.address), 32'd1);
    chk("t1_data1", 32'(bus16.write_data), 32'h5678);
    send_byte(0, 8'h08);
    chk("t1_done", 32'(done16), 32'd1);
    chk("t1_err", 32'(err16), 32'd0);
    chk("t1_busy_fall", 32'(busy16), 32'd0);
    chk("t1_ww", 32'(ww16), 32'd2);
    chk("t1_mem0", 32'(m16[0]), 32'h1234);
    chk("t1_mem1", 32'(m16[1]), 32'h5678);
    chk("t1_write_count", 32'(wr16), 32'd2);
    idle_cycle();
    chk("t1_done_one_cycle", 32'(done16), 32'd0);
    chk("t1_ww_hold", 32'(ww16), 32'd2);

    // 2: same frame, bad checksum
    send_byte(0, 8'hA5);
    chk("t2_ww_cleared", 32'(ww16), 32'd0);
    send_byte(0, 8'h02);
    send_byte(0, 8'h00);
    send_byte(0, 8'h34);
    send_byte(0, 8'h12);
    send_byte(0, 8'h78);
    send_byte(0, 8'h56);
    send_byte(0, 8'h09);
    chk("t2_err", 32'(err16), 32'd1);
    chk("t2_done", 32'(done16), 32'd0);
    chk("t2_write_count", 32'(wr16), 32'd4);
    chk("t2_ww", 32'(ww16), 32'd2);
    idle_cycle();

    // 3: empty frame, then stray bytes in IDLE
    send_byte(0, 8'hA5);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    chk("t3_done", 32'(done16), 32'd1);
    chk("t3_ww", 32'(ww16), 32'd0);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    chk("t3_idle_busy", 32'(busy16), 32'd0);
    chk("t3_no_done_again", 32'({done16, err16}), 32'd0);
    chk("t3_no_writes", 32'(wr16), 32'd4);
    idle_cycle();

    // 4: length too large for a 4-bit address space
    send_byte(1, 8'hA5);
    send_byte(1, 8'h10);
    send_byte(1, 8'h00);
    chk("t4_err", 32'(err4), 32'd1);
    chk("t4_busy", 32'(busy4), 32'd0);
    chk("t4_done", 32'(done4), 32'd0);
    chk("t4_no_writes", 32'(wr4), 32'd0);
    idle_cycle();

    // 5: byte-wide words, rx_valid held high through the whole frame
    send_byte(2, 8'hA5);
    send_byte(2, 8'h04);
    send_byte(2, 8'h00);
    send_byte(2, 8'h11);
    send_byte(2, 8'h22);
    send_byte(2, 8'h33);
    send_byte(2, 8'h44);
    send_byte(2, 8'h44);
    chk("t5_done", 32'(done8), 32'd1);
    chk("t5_ww", 32'(ww8), 32'd4);
    idle_cycle();
    chk("t5_write_count", 32'(wr8), 32'd4);
    chk("t5_we_cycles", 32'(we8_cycles), 32'd4);
    chk("t5_ready_low_in_write", 32'(ready_in_write8), 32'd0);
    chk("t5_mem0", 32'(m8[0]), 32'h11);
    chk("t5_mem1", 32'(m8[1]), 32'h22);
    chk("t5_mem2", 32'(m8[2]), 32'h33);
    chk("t5_mem3", 32'(m8[3]), 32'h44);
    chk("t5_log_len", 32'(addr8_log.size()), 32'd4);
    for (int i = 0; i < addr8_log.size(); i++) begin
      chk($sformatf("t5_addr_order_%0d", i), 32'(addr8_log[i]), 32'(i));
    end

    // 6a: drop enable after the third payload byte
    base = wr16;
    send_byte(0, 8'hA5);
    send_byte(0, 8'h03);
    send_byte(0, 8'h00);
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    send_byte(0, 8'h03);
    chk("t6_busy_before_abort", 32'(busy16), 32'd1);
    enable   = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t6_abort_busy", 32'(busy16), 32'd0);
    chk("t6_abort_pulses", 32'({done16, err16}), 32'd0);
    chk("t6_abort_ready", 32'(rdy16), 32'd1);
    chk("t6_kept_write", 32'(wr16 - base), 32'd1);
    chk("t6_mem0", 32'(m16[0]), 32'h0201);
    send_byte(0, 8'hA5);
    chk("t6_disabled_ignores_sync", 32'(busy16), 32'd0);
    enable = 1'b1;
    idle_cycle();

    // 6b: asynchronous reset during WRITE
    base = wr16;
    send_byte(0, 8'hA5);
    send_byte(0, 8'h01);
    send_byte(0, 8'h00);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    rx_valid = 1'b0;
    chk("t6_we_before_reset", 32'(bus16.write_enable), 32'd1);
    chk("t6_wdata_before_reset", 32'(bus16.write_data), 32'hBBAA);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we_async_drop", 32'(bus16.write_enable), 32'd0);
    chk("t6_reset_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_write_after_reset", 32'(wr16 - base), 32'd0);
    chk("t6_mem0_intact", 32'(m16[0]), 32'h0201);
    chk("t6_ready_after_reset", 32'(rdy16), 32'd1);
    chk("t6_ww_after_reset", 32'(ww16), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
